// File: rtl/pic_pkg.sv
// pic_pkg: shared ALU opcodes, instruction classes, decoder states and special file addresses
package pic_pkg;
  localparam logic [6:0] OP_NOP        = 7'b0000000;
  localparam logic [6:0] OP_CLRW       = 7'b0000010;
  localparam logic [6:0] OP_MOVWF      = 7'b0000001;
  localparam logic [6:0] OP_BCF_BASE   = 7'b0100000;
  localparam logic [6:0] OP_BSF_BASE   = 7'b0101000;
  localparam logic [6:0] OP_BTFSC_BASE = 7'b0110000;
  localparam logic [6:0] OP_BTFSS_BASE = 7'b0111000;
  localparam logic [1:0] CLS_BYTE = 2'b00;
  localparam logic [1:0] CLS_BIT  = 2'b01;
  localparam logic [1:0] CLS_JUMP = 2'b10;
  localparam logic [1:0] CLS_LIT  = 2'b11;
  localparam logic [6:0] FSR_ADDR  = 7'h04;
  localparam logic [6:0] INDF_ADDR = 7'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, EXECUTE = 2'd2, RETIRE = 2'd3} state_t;
  // Class 1x words have no ALU meaning here and issue as NOP.
  function automatic logic [6:0] decode_op(input logic [13:0] instr);
    return instr[13] ? OP_NOP : instr[13:7];
  endfunction
  // Byte ops with d=1 and BCF/BSF write their result back to the file.
  function automatic logic wr_en(input logic [13:0] instr);
    return (instr[13:12] == CLS_BYTE && instr[7]) || (instr[13:12] == CLS_BIT && !instr[11]);
  endfunction
endpackage

// File: rtl/file_regs.sv
// file_regs: FILE_DEPTH x 8 file register array, async read, sync write; INDF_EN adds an FSR tap
module file_regs
  import pic_pkg::*;
#(
  parameter int FILE_DEPTH = 128
) (
  input  logic       clk,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
`ifdef INDF_EN
  output logic [6:0] fsr,
`endif
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata
);
  logic [7:0] mem [FILE_DEPTH];
  assign rdata = 32'(raddr) < FILE_DEPTH ? mem[raddr] : 8'h00;
`ifdef INDF_EN
  assign fsr = mem[FSR_ADDR][6:0];
`endif
  // Storage is deliberately unreset; out-of-range writes are dropped.
  always_ff @(posedge clk)
    if (we && 32'(waddr) < FILE_DEPTH) mem[waddr] <= wdata;
endmodule

// File: rtl/instr_decode.sv
// instr_decode: 4-cycle issue stage feeding the PIC16F84 ALU; INDF_EN enables indirect addressing via FSR
module instr_decode
  import pic_pkg::*;
#(
  parameter int FILE_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [7:0]  F_OUT,
  output logic [6:0]  OP_CODE,
  output logic [7:0]  F_ADD,
  output logic        DONE,
  output logic        SKIP,
  output logic        UNSUPPORTED
);
  state_t     state_q, state_d;
  logic [6:0] hi_q, hi_d, ea_q, ea_d, op_q, op_d, ea;
  logic [7:0] fadd_q, fadd_d, rdata;
  logic       wr_q, wr_d, done_q, done_d, skip_q, skip_d, uns_q, uns_d, ea_ok, accept;
`ifdef INDF_EN
  logic [6:0] fsr;
`endif
  file_regs #(.FILE_DEPTH(FILE_DEPTH)) u_regs (
    .clk(clk), .raddr(ea), .rdata(rdata),
`ifdef INDF_EN
    .fsr(fsr),
`endif
    .we(state_q == EXECUTE && wr_q), .waddr(ea_q), .wdata(F_OUT)
  );
  // Effective file address of the incoming word; indirect slot 0 reads 0 and never writes.
  always_comb begin
`ifdef INDF_EN
    ea = INSTR[6:0] == INDF_ADDR ? fsr & 7'(FILE_DEPTH - 1) : INSTR[6:0];
    ea_ok = ea != INDF_ADDR;
`else
    ea = INSTR[6:0];
    ea_ok = 1'b1;
`endif
  end
  // Next-state: capture on accept, OP_CODE live only in DECODE, flags pulse in RETIRE.
  always_comb begin
    accept = state_q == IDLE && INSTR_VALID;
    state_d = state_q == IDLE ? (INSTR_VALID ? DECODE : IDLE) :
              state_q == DECODE ? EXECUTE : state_q == EXECUTE ? RETIRE : IDLE;
    hi_d = accept ? INSTR[13:7] : hi_q;
    ea_d = accept ? ea : ea_q;
    wr_d = accept ? wr_en(INSTR) && ea_ok : wr_q;
    fadd_d = accept ? (ea_ok ? rdata : 8'h00) : fadd_q;
    op_d = accept ? decode_op(INSTR) : OP_NOP;
    done_d = state_q == EXECUTE;
    uns_d = state_q == EXECUTE && hi_q[6];
    skip_d = state_q == EXECUTE && hi_q[6:4] == 3'b011 && fadd_q[hi_q[2:0]] == hi_q[3];
  end
  // Pipeline registers; reset lands in IDLE with the ALU seeing NOP.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      ea_q <= '0;
      wr_q <= 1'b0;
      fadd_q <= '0;
      op_q <= OP_NOP;
      done_q <= 1'b0;
      skip_q <= 1'b0;
      uns_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      ea_q <= ea_d;
      wr_q <= wr_d;
      fadd_q <= fadd_d;
      op_q <= op_d;
      done_q <= done_d;
      skip_q <= skip_d;
      uns_q <= uns_d;
    end
  assign INSTR_READY = state_q == IDLE;
  assign OP_CODE = op_q;
  assign F_ADD = fadd_q;
  assign DONE = done_q;
  assign SKIP = skip_q;
  assign UNSUPPORTED = uns_q;
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed and random checks of instr_decode against an instruction-level model
module tb_instr_decode;
  logic        clk = 0, rst = 1, INSTR_VALID = 0, INSTR_READY, DONE, SKIP, UNSUPPORTED;
  logic [13:0] INSTR = 0;
  logic [7:0]  F_OUT = 0, F_ADD;
  logic [6:0]  OP_CODE;
  int checks = 0, failures = 0;

  instr_decode dut (
    .clk(clk), .rst(rst), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .F_OUT(F_OUT), .OP_CODE(OP_CODE), .F_ADD(F_ADD), .DONE(DONE), .SKIP(SKIP), .UNSUPPORTED(UNSUPPORTED)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Instruction-level model: k counts cycles since accept (0 = waiting).
  int         k = 0;
  logic [7:0] mfile [128];
  logic [7:0] m_fadd = 0;
  logic [6:0] m_op = 0, m_ea = 0;
  logic       m_wr = 0, m_skip = 0, m_uns = 0;
  initial for (int i = 0; i < 128; i++) mfile[i] = 8'h00;

  always @(posedge clk or posedge rst) begin : model
    logic [6:0] a;
    logic       ok;
    if (rst) begin
      k = 0;
      m_fadd = 0;
    end else if (k == 0) begin
      if (INSTR_VALID) begin
        a = INSTR[6:0];
        ok = 1;
`ifdef INDF_EN
        if (a == 0) begin
          a = mfile[4][6:0];
          ok = a != 0;
        end
`endif
        m_ea = a;
        m_fadd = ok ? mfile[a] : 8'h00;
        m_uns = INSTR[13];
        m_op = INSTR[13] ? 7'd0 : INSTR[13:7];
        m_wr = ok && ((INSTR[13:12] == 0 && INSTR[7]) || (INSTR[13:12] == 1 && !INSTR[11]));
        m_skip = INSTR[13:11] == 3'b011 && (INSTR[10] ? m_fadd[INSTR[9:7]] : !m_fadd[INSTR[9:7]]);
        k = 1;
      end
    end else begin
      if (k == 2 && m_wr) mfile[m_ea] = F_OUT;
      k = (k + 1) % 4;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) if (!rst) begin
    chk("ready", {7'd0, INSTR_READY}, {7'd0, k == 0});
    chk("op", {1'b0, OP_CODE}, k == 1 ? {1'b0, m_op} : 8'h00);
    chk("fadd", F_ADD, m_fadd);
    chk("done", {7'd0, DONE}, {7'd0, k == 3});
    chk("skip", {7'd0, SKIP}, {7'd0, k == 3 && m_skip});
    chk("unsupported", {7'd0, UNSUPPORTED}, {7'd0, k == 3 && m_uns});
    if (k == 3 && m_wr) chk("writeback", dut.u_regs.mem[m_ea], mfile[m_ea]);
  end

  logic [6:0] c_op;
  logic [7:0] c_fa;
  logic       c_sk, c_un, c_dn;

  task automatic run(input logic [13:0] ins, input logic [7:0] fo);
    int n = 0;
    @(negedge clk);
    INSTR = ins; INSTR_VALID = 1; F_OUT = fo;
    while (!INSTR_READY && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 8'd0, 8'd1);
    @(negedge clk);
    INSTR_VALID = 0; c_op = OP_CODE; c_fa = F_ADD;
    @(negedge clk);
    @(negedge clk);
    c_sk = SKIP; c_un = UNSUPPORTED; c_dn = DONE;
  endtask

  task automatic movwf(input logic [6:0] a, input logic [7:0] v);
    run({7'b0000001, a}, v);
  endtask

  initial begin
    int n, low, dn_seen;
    repeat (2) @(negedge clk);
    chk("rst_ready", {7'd0, INSTR_READY}, 8'd1);
    chk("rst_op", {1'b0, OP_CODE}, 8'd0);
    chk("rst_fadd", F_ADD, 8'd0);
    chk("rst_flags", {5'd0, DONE, SKIP, UNSUPPORTED}, 8'd0);
    #2 rst = 0;
`ifdef INDF_EN
    for (int a = 1; a < 128; a++) movwf(7'(a), 8'($urandom));
`else
    for (int a = 0; a < 128; a++) movwf(7'(a), 8'($urandom));
`endif
    movwf(7'h10, 8'h05);
    run(14'b00_1010_1_0010000, 8'h06);
    chk("incf_op", {1'b0, c_op}, 8'b0010101);
    chk("incf_fadd", c_fa, 8'h05);
    chk("incf_done", {7'd0, c_dn}, 8'd1);
    chk("incf_file", dut.u_regs.mem[7'h10], 8'h06);
    movwf(7'h20, 8'h33);
    run(14'b00_0111_0_0100000, 8'h99);
    chk("addwf_op", {1'b0, c_op}, 8'b0001110);
    chk("addwf_skip", {7'd0, c_sk}, 8'd0);
    chk("addwf_file", dut.u_regs.mem[7'h20], 8'h33);
    movwf(7'h0C, 8'h00);
    run(14'b01_1001_1_0001100, 8'hFF);
    chk("btfsc_skip1", {6'd0, c_sk, c_dn}, 8'd3);
    chk("btfsc_nowrite0", dut.u_regs.mem[7'h0C], 8'h00);
    movwf(7'h0C, 8'h08);
    run(14'b01_1001_1_0001100, 8'hFF);
    chk("btfsc_skip0", {6'd0, c_sk, c_dn}, 8'd1);
    chk("btfsc_nowrite8", dut.u_regs.mem[7'h0C], 8'h08);
    @(negedge clk);
    INSTR = 14'b01_0111_1_0001100; INSTR_VALID = 1; F_OUT = 8'h88;
    n = 0;
    while (!INSTR_READY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    INSTR = 14'b00_1000_0_0001100;
    low = 0;
    while (!INSTR_READY && low < 20) begin @(negedge clk); low++; end
    chk("b2b_ready_low", 8'(low), 8'd3);
    @(negedge clk);
    INSTR_VALID = 0;
    chk("b2b_op", {1'b0, OP_CODE}, 8'b0010000);
    chk("b2b_fadd", F_ADD, 8'h88);
    repeat (2) @(negedge clk);
    movwf(7'h05, 8'h5A);
    run(14'h2805, 8'h11);
    chk("goto_op", {1'b0, c_op}, 8'd0);
    chk("goto_flags", {6'd0, c_un, c_dn}, 8'd3);
    chk("goto_nowrite", dut.u_regs.mem[7'h05], 8'h5A);
    movwf(7'h15, 8'hAA);
    @(negedge clk);
    INSTR = 14'b00_0001_1_0010101; INSTR_VALID = 1; F_OUT = 8'h00;
    n = 0;
    while (!INSTR_READY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    INSTR_VALID = 0;
    @(posedge clk);
    #2 rst = 1;
    dn_seen = 0;
    @(negedge clk);
    #2 rst = 0;
    repeat (4) begin @(negedge clk); dn_seen += DONE; end
    chk("rst_exec_done", 8'(dn_seen), 8'd0);
    chk("rst_exec_file", dut.u_regs.mem[7'h15], 8'hAA);
    chk("rst_exec_ready", {7'd0, INSTR_READY}, 8'd1);
    chk("rst_exec_op", {1'b0, OP_CODE}, 8'd0);
`ifdef INDF_EN
    movwf(7'h04, 8'h15);
    run(14'b00_0001_1_0000000, 8'h00);
    chk("indf_clrf", dut.u_regs.mem[7'h15], 8'h00);
`endif
    repeat (1500) begin
      @(negedge clk);
      INSTR = 14'($urandom);
      INSTR_VALID = $urandom_range(0, 3) != 0;
      F_OUT = 8'($urandom);
    end
    @(negedge clk);
    INSTR_VALID = 0;
    repeat (6) @(negedge clk);
`ifdef INDF_EN
    for (int a = 1; a < 128; a++) chk("final_file", dut.u_regs.mem[a], mfile[a]);
`else
    for (int a = 0; a < 128; a++) chk("final_file", dut.u_regs.mem[a], mfile[a]);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Upstream issue stage for the PIC16F84 ALU: accepts one 14-bit instruction word, reads the addressed file register, and drives a one-cycle OP_CODE/F_ADD pair to the ALU.
- Writes the ALU's F_OUT back to the file when the destination is f.
- Evaluates BTFSC/BTFSS skip conditions.
- Owns the file register array. The PC/fetch stage feeds it through a valid/ready handshake.

Parameters:
- FILE_DEPTH, 128: number of 8-bit file registers. Address range 0..FILE_DEPTH-1; 7-bit address field.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- INSTR  in  14  instruction word
- INSTR_VALID  in  1  INSTR is valid
- INSTR_READY  out  1  block can accept an instruction
- F_OUT  in  8  ALU result, driven by the ALU
- OP_CODE  out  7  ALU operation code
- F_ADD  out  8  file operand to the ALU
- DONE  out  1  one-cycle pulse when an instruction retires
- SKIP  out  1  one-cycle pulse with DONE; next instruction must be skipped
- UNSUPPORTED  out  1  one-cycle pulse with DONE; class 10/11 instruction

Behaviour:
- Reset (async, any state): state=IDLE, OP_CODE=7'b0000000 (NOP), F_ADD=0, DONE=SKIP=UNSUPPORTED=0, INSTR_READY=1.
- File contents are not reset. Simulation initialises them to 0.
- States: IDLE -> DECODE -> EXECUTE -> RETIRE -> IDLE. Fixed 4 cycles per instruction, mirroring Q1..Q4.
- INSTR_READY=1 only in IDLE.
- Accept edge (IDLE with INSTR_VALID=1):
  - latch INSTR, addr=INSTR[6:0]
  - register F_ADD=file[addr]
  - register OP_CODE
- Without INSTR_VALID, IDLE holds.
- OP_CODE encoding:
  - INSTR[13:12]=00 or 01: OP_CODE=INSTR[13:7]. Byte ops give {00,op[11:8],d}; bit ops give {01,type,bbb}.
  - INSTR[13:12]=1x: OP_CODE=NOP, and UNSUPPORTED is flagged.
- OP_CODE holds its decoded value only during DECODE. It is NOP in every other state, so the ALU executes exactly once, on the DECODE->EXECUTE edge.
- F_OUT is sampled during EXECUTE.
- Write-back occurs on the EXECUTE->RETIRE edge: file[addr]<=F_OUT when wr_en=1.
  - wr_en = (class 00 and INSTR[7]=1) or (class 01 and INSTR[11]=0, i.e. BCF/BSF).
  - No write for BTFSC/BTFSS, NOP/CLRW, W-destination ops, or class 1x.
- Skip condition, from the DECODE-cycle F_ADD:
  - BTFSC (0110bbb): skip if F_ADD[bbb]=0.
  - BTFSS (0111bbb): skip if F_ADD[bbb]=1.
  - The result is registered and pulsed on SKIP during RETIRE.
- RETIRE: DONE=1 for exactly one cycle. Then IDLE; the next accept is no earlier than the following cycle.
- Address >= FILE_DEPTH: reads give 0; writes are dropped.
- Read-after-write: write completes before the next accept edge, so back-to-back RMW to the same address sees the new value. No bypass is needed.
- Reset asserted in DECODE or EXECUTE: no write-back, no DONE. The ALU sees NOP from reset onward.
- INSTR changes while not in IDLE are ignored.

Optional Feature:
- Macro INDF_EN.
- Defined: address 0x00 is INDF.
  - Effective address = file[0x04] (FSR) & (FILE_DEPTH-1) for both read and write-back.
  - Effective address 0x00 reads 0; writes to it are dropped.
  - The FSR value is sampled at the accept edge.
- Undefined: address 0x00 is an ordinary register.

Decomposition:
- Shared package pic_pkg:
  - ALU opcode constants: OP_NOP=7'b0000000, OP_CLRW, OP_MOVWF, OP_BCF_BASE=7'b0100000, OP_BSF_BASE, OP_BTFSC_BASE, OP_BTFSS_BASE
  - instruction class codes (2'b00 byte, 2'b01 bit, 2'b10 call/goto, 2'b11 literal)
  - state enum (IDLE, DECODE, EXECUTE, RETIRE)
  - FSR_ADDR=7'h04, INDF_ADDR=7'h00
- Sub-module file_regs: FILE_DEPTH x 8 array with async read and sync write port. It keeps the FSM separate from storage.

Test Plan:
- Reset, then INCF 0x10,f (14'b00_1010_1_0010000), file[0x10]=0x05, ALU model returns F_OUT=0x06:
  - OP_CODE=0010101 exactly 1 cycle after accept, F_ADD=0x05.
  - file[0x10]=0x06 at RETIRE; DONE pulse 3 cycles after accept.
- ADDWF 0x20,w (d=0):
  - OP_CODE=0001110.
  - file[0x20] unchanged; SKIP=0.
- BTFSC 0x0C,3 with file[0x0C]=0x00 -> SKIP=1 with DONE. With file[0x0C]=0x08 -> SKIP=0. No file write in either case.
- BSF 0x0C,7 then MOVF 0x0C,w back-to-back, INSTR_VALID held high:
  - second F_ADD=0x80 | old value.
  - INSTR_READY low for 3 cycles between accepts.
- GOTO word 14'h2805 -> OP_CODE stays NOP throughout, UNSUPPORTED=1 with DONE, no write.
- Assert rst during EXECUTE of CLRF 0x15 (file=0xAA):
  - file[0x15] stays 0xAA, no DONE.
  - After release, INSTR_READY=1 and OP_CODE=NOP.
  - With INDF_EN defined, CLRF 0x00 with FSR=0x15 clears file[0x15].
